// File: rtl/niios_qsys_sample_writer_if.sv
// rtl/niios_qsys_sample_writer_if.sv - sample stream, CSR slave and RAM write port bundle
// Groups the three buses of the sample writer. The slave modport is the
// writer's own view; the master modport is the surrounding system's view.
interface niios_qsys_sample_writer_if #(
   parameter int ADDR_W = 13
);
   // 16-bit ADC sample stream
   logic [15:0]       snk_data;
   logic              snk_valid;
   logic              snk_ready;
   // CSR slave
   logic [1:0]        csr_address;
   logic              csr_read;
   logic              csr_write;
   logic [31:0]       csr_writedata;
   logic [31:0]       csr_readdata;
   // RAM write master
   logic [ADDR_W-1:0] ram_address;
   logic [3:0]        ram_byteenable;
   logic              ram_chipselect;
   logic              ram_write;
   logic [31:0]       ram_writedata;
   logic              ram_waitrequest;
   // buffer pass interrupt
   logic              irq;

   modport slave (
      input  snk_data, snk_valid,
      input  csr_address, csr_read, csr_write, csr_writedata,
      input  ram_waitrequest,
      output snk_ready, csr_readdata,
      output ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata,
      output irq
   );

   modport master (
      output snk_data, snk_valid,
      output csr_address, csr_read, csr_write, csr_writedata,
      output ram_waitrequest,
      input  snk_ready, csr_readdata,
      input  ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata,
      input  irq
   );
endinterface

// File: rtl/niios_qsys_sample_writer.sv
// rtl/niios_qsys_sample_writer.sv - packs 16-bit samples into 32-bit words and writes them to on-chip RAM
// Samples are paired into words, queued in a small FIFO and written to
// BASE+offset, either once over LENGTH words or circularly. Software controls
// it through four CSRs and gets a level interrupt when a pass completes.
module niios_qsys_sample_writer #(
   parameter int ADDR_W     = 13,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   niios_qsys_sample_writer_if.slave bus
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PTR_W:0] FIFO_FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic              run, busy, snk_ready;

   // CSR state
   logic              wrap, irq_en;
   logic [12:0]       base, length;
   logic [12:0]       offset, offset_nxt, word_count;
   logic              done, overflow;
   logic [31:0]       readdata_q;

   // pack register
   logic [15:0]       pack_lo;
   logic              pack_half;

   // packed-word FIFO
   logic [31:0]       fifo_data [FIFO_DEPTH];
   logic [3:0]        fifo_be   [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [PTR_W:0]    fifo_count;
   logic              fifo_full, fifo_empty;
   logic              push, pop, pair_push, flush_push;
   logic [31:0]       push_data;
   logic [3:0]        push_be;

   // registered RAM master outputs
   logic [ADDR_W-1:0] ram_address_q;
   logic [3:0]        ram_be_q;
   logic              ram_cs_q, ram_write_q;
   logic [31:0]       ram_data_q;
   logic [12:0]       ram_addr_sum;

   // control events
   logic              ctrl_wr, base_wr, len_wr, stat_wr;
   logic              start, sw_stop, hw_stop;
   logic              wr_fire, pass_end, accept, overflow_set;
   logic              unused_wdata;

   assign ctrl_wr = bus.csr_write & (bus.csr_address == 2'd0);
   assign base_wr = bus.csr_write & (bus.csr_address == 2'd1);
   assign len_wr  = bus.csr_write & (bus.csr_address == 2'd2);
   assign stat_wr = bus.csr_write & (bus.csr_address == 2'd3);

   // A run request only starts a pass from IDLE and with a non-empty buffer.
   assign start   = ctrl_wr & bus.csr_writedata[0] & (state == S_IDLE) & (length != 13'd0);
   assign sw_stop = ctrl_wr & ~bus.csr_writedata[0];

   assign wr_fire  = ram_write_q & ~bus.ram_waitrequest;
   assign pass_end = wr_fire & (offset == length - 13'd1);
   assign hw_stop  = pass_end & ~wrap;

   assign accept       = bus.snk_valid & snk_ready;
   assign overflow_set = bus.snk_valid & ~snk_ready & (state == S_FILL);

   assign fifo_full  = (fifo_count == FIFO_FULL_CNT);
   assign fifo_empty = (fifo_count == '0);

   // The head is only moved into the output register while the slave is not
   // stalling, so the RAM outputs never change under waitrequest.
   assign pop        = ~fifo_empty & ~bus.ram_waitrequest;
   assign pair_push  = accept & pack_half;
   assign flush_push = (state == S_DRAIN) & pack_half & (~fifo_full | pop);
   assign push       = pair_push | flush_push;
   assign push_data  = pair_push ? {bus.snk_data, pack_lo} : {16'h0000, pack_lo};
   assign push_be    = pair_push ? 4'b1111 : 4'b0011;

   assign snk_ready = run & ~fifo_full;

   assign bus.snk_ready      = snk_ready;
   assign bus.csr_readdata   = readdata_q;
   assign bus.ram_address    = ram_address_q;
   assign bus.ram_byteenable = ram_be_q;
   assign bus.ram_chipselect = ram_cs_q;
   assign bus.ram_write      = ram_write_q;
   assign bus.ram_writedata  = ram_data_q;
   assign bus.irq            = done & irq_en;

   assign unused_wdata = ^{bus.csr_writedata[31:18], bus.csr_writedata[15:13]};

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next state: start on a run write, drain on software or end-of-pass stop.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (start)                                      state_nxt = S_FILL;
         S_FILL:  if (sw_stop | hw_stop)                          state_nxt = S_DRAIN;
         S_DRAIN: if (~pack_half & fifo_empty & ~ram_write_q)     state_nxt = S_IDLE;
         default:                                                 state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs: run is exactly "capturing", busy is "not idle".
   always_comb begin
      run  = (state == S_FILL);
      busy = (state != S_IDLE);
   end

   // Offset of the word the output register holds next; a pop in the same
   // cycle as a completing write must already see the advanced offset.
   always_comb begin
      offset_nxt = offset;
      if (wr_fire) offset_nxt = (pass_end & wrap) ? 13'd0 : offset + 13'd1;
   end

   assign ram_addr_sum = base + offset_nxt;

   // CSR registers; hardware sets of done/overflow win over a W1C.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrap     <= 1'b0;
         irq_en   <= 1'b0;
         base     <= 13'd0;
         length   <= 13'd0;
         done     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            wrap   <= bus.csr_writedata[1];
            irq_en <= bus.csr_writedata[2];
         end
         if (base_wr & ~busy) base   <= bus.csr_writedata[12:0];
         if (len_wr & ~busy)  length <= bus.csr_writedata[12:0];
         if (pass_end)                            done <= 1'b1;
         else if (stat_wr & bus.csr_writedata[16]) done <= 1'b0;
         if (overflow_set)                        overflow <= 1'b1;
         else if (stat_wr & bus.csr_writedata[17]) overflow <= 1'b0;
      end
   end

   // Registered CSR read data, valid the cycle after csr_read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) readdata_q <= 32'd0;
      else if (bus.csr_read) begin
         unique case (bus.csr_address)
            2'd0: readdata_q <= {29'd0, irq_en, wrap, run};
            2'd1: readdata_q <= {19'd0, base};
            2'd2: readdata_q <= {19'd0, length};
            2'd3: readdata_q <= {13'd0, busy, overflow, done, 3'd0, word_count};
            default: readdata_q <= 32'd0;
         endcase
      end
   end

   // Write position and saturating count of words written this pass.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         offset     <= 13'd0;
         word_count <= 13'd0;
      end else if (start) begin
         offset     <= 13'd0;
         word_count <= 13'd0;
      end else if (wr_fire) begin
         offset <= offset_nxt;
         if (word_count < length) word_count <= word_count + 13'd1;
      end
   end

   // Pack register: low half first, word is pushed on the high half.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pack_lo   <= 16'h0000;
         pack_half <= 1'b0;
      end else if (start) begin
         pack_half <= 1'b0;
      end else if (accept) begin
         if (!pack_half) begin
            pack_lo   <= bus.snk_data;
            pack_half <= 1'b1;
         end else begin
            pack_half <= 1'b0;
         end
      end else if (flush_push) begin
         pack_half <= 1'b0;
      end
   end

   // FIFO storage; a push while full writes the slot being popped this cycle.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= push_data;
         fifo_be[wr_ptr]   <= push_be;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         unique case ({push, pop})
            2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
            2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Write engine: load the FIFO head into the RAM outputs, drop the request
   // once it completes with nothing queued behind it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ram_address_q <= '0;
         ram_be_q      <= 4'b0000;
         ram_cs_q      <= 1'b0;
         ram_write_q   <= 1'b0;
         ram_data_q    <= 32'd0;
      end else if (pop) begin
         ram_address_q <= ADDR_W'(ram_addr_sum);
         ram_be_q      <= fifo_be[rd_ptr];
         ram_data_q    <= fifo_data[rd_ptr];
         ram_cs_q      <= 1'b1;
         ram_write_q   <= 1'b1;
      end else if (wr_fire) begin
         ram_cs_q      <= 1'b0;
         ram_write_q   <= 1'b0;
      end
   end

endmodule
